// File: rtl/arbitro_mem_datos_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : arbitro_mem_datos_if                                              |
// | Brief  : Bundle of the CPU, DMA and data-memory buses of the data-memory   |
// |          arbiter.                                                          |
// |          slave  : view of the arbiter (consumes requests, drives memory).  |
// |          master : view of the environment (CPU, DMA and memoria_datos).    |
// | Ports  : cpu_*  CPU MEM-stage address/data/strobes, read data, stall       |
// |          dma_*  DMA req/gnt handshake, address/data/strobes, read data     |
// |          mem_*  memoria_datos address, write data, read data, RD/WR        |
// | Rev    : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface arbitro_mem_datos_if #(
  parameter int ANCHO_DATO = 32,
  parameter int ANCHO_DIR  = 32
);
  logic [ANCHO_DIR-1:0]  cpu_dir;
  logic [ANCHO_DATO-1:0] cpu_dato_wr;
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [ANCHO_DATO-1:0] cpu_dato_rd;
  logic                  cpu_stall;

  logic                  dma_req;
  logic                  dma_gnt;
  logic [ANCHO_DIR-1:0]  dma_dir;
  logic [ANCHO_DATO-1:0] dma_dato_wr;
  logic                  dma_rd;
  logic                  dma_wr;
  logic [ANCHO_DATO-1:0] dma_dato_rd;

  logic [ANCHO_DIR-1:0]  mem_dir;
  logic [ANCHO_DATO-1:0] mem_dato_entrada;
  logic [ANCHO_DATO-1:0] mem_dato_salida;
  logic                  mem_rd;
  logic                  mem_wr;

  modport slave (
    input  cpu_dir, cpu_dato_wr, cpu_rd, cpu_wr,
    output cpu_dato_rd, cpu_stall,
    input  dma_req, dma_dir, dma_dato_wr, dma_rd, dma_wr,
    output dma_gnt, dma_dato_rd,
    output mem_dir, mem_dato_entrada, mem_rd, mem_wr,
    input  mem_dato_salida
  );

  modport master (
    output cpu_dir, cpu_dato_wr, cpu_rd, cpu_wr,
    input  cpu_dato_rd, cpu_stall,
    output dma_req, dma_dir, dma_dato_wr, dma_rd, dma_wr,
    input  dma_gnt, dma_dato_rd,
    input  mem_dir, mem_dato_entrada, mem_rd, mem_wr,
    output mem_dato_salida
  );
endinterface
`default_nettype wire

// File: rtl/arbitro_mem_datos.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : arbitro_mem_datos                                                 |
// | Brief  : Arbitrates the single data-memory port between the CPU datapath   |
// |          (default owner) and the DMA engine (req/gnt, bounded bursts, then |
// |          a one-cycle turnaround and a guard interval for the CPU).         |
// | Ports  : clk      system clock, rising edge                                |
// |          reset_n  asynchronous active-low reset                            |
// |          bus      arbiter view (slave) of the CPU/DMA/memory buses         |
// | Rev    : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module arbitro_mem_datos #(
  parameter int ANCHO_DATO = 32,
  parameter int ANCHO_DIR  = 32,
  parameter int MAX_RAFAGA = 16,
  parameter int ESPERA_CPU = 2
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  arbitro_mem_datos_if.slave   bus
);

  localparam int ANCHO_BEATS  = $clog2(MAX_RAFAGA + 1);
  localparam int ANCHO_GUARDA = (ESPERA_CPU > 0) ? $clog2(ESPERA_CPU + 1) : 1;

  localparam logic [ANCHO_BEATS-1:0]  C_ULTIMO_BEAT = ANCHO_BEATS'(MAX_RAFAGA - 1);
  localparam logic [ANCHO_BEATS-1:0]  C_BEAT_UNO    = ANCHO_BEATS'(1);
  localparam logic [ANCHO_GUARDA-1:0] C_GUARDA_INI  = ANCHO_GUARDA'(ESPERA_CPU);
  localparam logic [ANCHO_GUARDA-1:0] C_GUARDA_UNO  = ANCHO_GUARDA'(1);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    DMA     = 2'd1,
    LIBERAR = 2'd2
  } estado_t;

  estado_t                 estado_q;
  logic [ANCHO_GUARDA-1:0] guarda_q;
  logic [ANCHO_BEATS-1:0]  beats_q;
  logic                    gnt_q;

  logic                    w_beat;
  logic [ANCHO_DIR-1:0]    w_dir;
  logic [ANCHO_DATO-1:0]   w_dato;
  logic                    w_rd_src;
  logic                    w_wr_src;
  logic                    w_strobes_on;

  assign w_beat = bus.dma_rd | bus.dma_wr;

  // State, guard and beat counters plus the registered grant, all in one block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= REPOSO;
      guarda_q <= '0;
      beats_q  <= '0;
      gnt_q    <= 1'b0;
    end else begin
      case (estado_q)
        REPOSO: begin
          // The CPU is still served in this deciding cycle; DMA takes over next.
          if (bus.dma_req && (guarda_q == '0)) begin
            estado_q <= DMA;
            gnt_q    <= 1'b1;
          end else if (guarda_q != '0) begin
            guarda_q <= guarda_q - C_GUARDA_UNO;
          end
        end
        DMA: begin
          if (w_beat) begin
            beats_q <= beats_q + C_BEAT_UNO;
          end
          // Dropping req still serves this cycle's DMA strobes before leaving.
          if (!bus.dma_req || (w_beat && (beats_q == C_ULTIMO_BEAT))) begin
            estado_q <= LIBERAR;
            gnt_q    <= 1'b0;
          end
        end
        LIBERAR: begin
          estado_q <= REPOSO;
          guarda_q <= C_GUARDA_INI;
          beats_q  <= '0;
        end
        default: begin
          estado_q <= REPOSO;
          gnt_q    <= 1'b0;
        end
      endcase
    end
  end

  // Source mux: DMA only while it owns the port; the CPU otherwise, including
  // the turnaround cycle, where only its strobes are gated off.
  always_comb begin
    w_dir        = bus.cpu_dir;
    w_dato       = bus.cpu_dato_wr;
    w_rd_src     = bus.cpu_rd;
    w_wr_src     = bus.cpu_wr;
    w_strobes_on = (estado_q != LIBERAR);
    if (estado_q == DMA) begin
      w_dir    = bus.dma_dir;
      w_dato   = bus.dma_dato_wr;
      w_rd_src = bus.dma_rd;
      w_wr_src = bus.dma_wr;
    end
  end

  // A simultaneous rd+wr from the owner resolves to a write.
  assign bus.mem_dir          = w_dir;
  assign bus.mem_dato_entrada = w_dato;
  assign bus.mem_wr           = w_strobes_on & w_wr_src;
  assign bus.mem_rd           = w_strobes_on & w_rd_src & ~w_wr_src;

  assign bus.cpu_stall   = (bus.cpu_rd | bus.cpu_wr) & (estado_q != REPOSO);
  assign bus.dma_gnt     = gnt_q;
  assign bus.cpu_dato_rd = bus.mem_dato_salida;
  assign bus.dma_dato_rd = bus.mem_dato_salida;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_mem_datos.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_arbitro_mem_datos                                              |
// | Brief  : Self-checking bench for arbitro_mem_datos: directed scenarios     |
// |          followed by random traffic, compared against a behavioural model |
// |          of ownership, guard time, burst length and memory contents.       |
// | Rev    : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_arbitro_mem_datos;

  localparam int MAX_RAFAGA = 16;
  localparam int ESPERA_CPU = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic borrar;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  arbitro_mem_datos_if #(.ANCHO_DATO(32), .ANCHO_DIR(32)) bus ();

  arbitro_mem_datos #(
    .ANCHO_DATO (32),
    .ANCHO_DIR  (32),
    .MAX_RAFAGA (MAX_RAFAGA),
    .ESPERA_CPU (ESPERA_CPU)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Physical memory: combinational read, write on the rising edge.
  logic [31:0] mem_fis [0:1023];
  assign bus.mem_dato_salida = mem_fis[bus.mem_dir[11:2]];
  always @(posedge clk) begin
    if (borrar) begin
      for (int i = 0; i < 1024; i++) mem_fis[i] <= 32'h0;
    end else if (bus.mem_wr) begin
      mem_fis[bus.mem_dir[11:2]] <= bus.mem_dato_entrada;
    end
  end

  // Reference model: who owns the port (0 CPU, 1 DMA, 2 turnaround),
  // remaining guard cycles, beats in the current grant, expected memory.
  int          owner;
  int          guard;
  int          nbeats;
  logic [31:0] model_mem [0:1023];

  logic        e_gnt, e_stall, e_rd, e_wr;
  logic [31:0] e_dir, e_dato;

  task automatic model_reset();
    owner  = 0;
    guard  = 0;
    nbeats = 0;
  endtask

  task automatic calc_exp();
    logic s_rd, s_wr;
    e_gnt   = (owner == 1);
    e_stall = (bus.cpu_rd | bus.cpu_wr) && (owner != 0);
    e_dir   = (owner == 1) ? bus.dma_dir : bus.cpu_dir;
    e_dato  = (owner == 1) ? bus.dma_dato_wr : bus.cpu_dato_wr;
    s_rd    = (owner == 1) ? bus.dma_rd : bus.cpu_rd;
    s_wr    = (owner == 1) ? bus.dma_wr : bus.cpu_wr;
    e_wr    = (owner != 2) && s_wr;
    e_rd    = (owner != 2) && s_rd && !s_wr;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    calc_exp();
    chk({tag, "_gnt"},   32'(bus.dma_gnt),   32'(e_gnt));
    chk({tag, "_stall"}, 32'(bus.cpu_stall), 32'(e_stall));
    chk({tag, "_rd"},    32'(bus.mem_rd),    32'(e_rd));
    chk({tag, "_wr"},    32'(bus.mem_wr),    32'(e_wr));
    chk({tag, "_dir"},   bus.mem_dir,        e_dir);
    chk({tag, "_dato"},  bus.mem_dato_entrada, e_dato);
    if (e_rd && owner == 0) chk({tag, "_cpu_q"}, bus.cpu_dato_rd, model_mem[e_dir[11:2]]);
    if (e_rd && owner == 1) chk({tag, "_dma_q"}, bus.dma_dato_rd, model_mem[e_dir[11:2]]);
  endtask

  // Advance the model across one rising edge using the inputs held over it.
  task automatic clock_model();
    calc_exp();
    if (e_wr) model_mem[e_dir[11:2]] = e_dato;
    if (!reset_n) begin
      model_reset();
    end else begin
      case (owner)
        0: begin
          if (bus.dma_req && guard == 0) owner = 1;
          else if (guard > 0) guard--;
        end
        1: begin
          if (bus.dma_rd || bus.dma_wr) nbeats++;
          if (!bus.dma_req || nbeats == MAX_RAFAGA) owner = 2;
        end
        default: begin
          owner  = 0;
          guard  = ESPERA_CPU;
          nbeats = 0;
        end
      endcase
    end
  endtask

  task automatic drive(input logic req, input logic crd, input logic cwr,
                       input logic [31:0] cdir, input logic [31:0] cdat,
                       input logic drd, input logic dwr,
                       input logic [31:0] ddir, input logic [31:0] ddat);
    bus.dma_req     = req;
    bus.cpu_rd      = crd;
    bus.cpu_wr      = cwr;
    bus.cpu_dir     = cdir;
    bus.cpu_dato_wr = cdat;
    bus.dma_rd      = drd;
    bus.dma_wr      = dwr;
    bus.dma_dir     = ddir;
    bus.dma_dato_wr = ddat;
  endtask

  // One cycle: called at a falling edge, checks mid-cycle, crosses the rising edge.
  task automatic step(input string tag, input logic req, input logic crd, input logic cwr,
                      input logic [31:0] cdir, input logic [31:0] cdat,
                      input logic drd, input logic dwr,
                      input logic [31:0] ddir, input logic [31:0] ddat);
    drive(req, crd, cwr, cdir, cdat, drd, dwr, ddir, ddat);
    #1;
    check_all(tag);
    @(posedge clk);
    clock_model();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
    model_reset();
    borrar  = 1'b1;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 borrar = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state.
    step("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("reset_gnt_const", 32'(bus.dma_gnt), 32'h0);

    // CPU only: write then read back.
    step("t2_wr", 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("t2_rd_const", bus.cpu_dato_rd, 32'hDEADBEEF);
    chk("t2_stall_const", 32'(bus.cpu_stall), 32'h0);
    @(negedge clk);
    step("t2_rd", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // DMA burst: grant, CPU stalled, four writes, req drop, turnaround.
    step("t3_c0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step("t3_c1", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int b = 0; b < 4; b++)
      step("t3_beat", 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1,
           32'h100 + 32'(4 * b), 32'hA000 + 32'(b));
    step("t3_c5", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step("t3_c6", 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step("t3_c7", 1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Burst cap and guard interval with req held and writes every cycle.
    for (int k = 0; k < 2 * (MAX_RAFAGA + 5); k++)
      step("t4_cap", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1,
           32'h200 + 32'(4 * (k % 32)), $urandom);
    step("t4_end", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    while (owner != 0)
      step("t4_drain", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Strobe clash inside a grant, then guard window with CPU traffic.
    step("t5_req", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step("t5_clash", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h300, 32'h5A5A5A5A);
    step("t5_rd", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
    for (int k = 0; k < 6; k++)
      step("t6_guard", 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset during beat 3 of a burst.
    step("t1_req", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    while (owner != 0)
      step("t1_wait", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h380, 32'h1);
    step("t1_req2", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    while (owner != 1 && guard >= 0 && checks < 5000)
      step("t1_grant", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step("t1_b1", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h400, 32'hB1);
    step("t1_b2", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h404, 32'hB2);
    drive(1'b1, 1'b0, 1'b1, 32'h20, 32'h1234, 1'b0, 1'b1, 32'h408, 32'hB3);
    #1;
    check_all("t1_pre");
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_all("t1_rst");
    chk("t1_gnt_const", 32'(bus.dma_gnt), 32'h0);
    chk("t1_wr_const", 32'(bus.mem_wr), 32'h1);
    chk("t1_dir_const", bus.mem_dir, 32'h20);
    @(posedge clk);
    clock_model();
    @(negedge clk);
    reset_n = 1'b1;
    step("t1_after", 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < MAX_RAFAGA + 4; k++)
      step("t1_full", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h500 + 32'(4 * k), $urandom);

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      logic req, crd, cwr, drd, dwr;
      req = ($urandom_range(0, 9) < 6);
      crd = $urandom_range(0, 1);
      cwr = ($urandom_range(0, 3) == 0);
      drd = $urandom_range(0, 1);
      dwr = $urandom_range(0, 1);
      step("rnd", req, crd, cwr, {22'h0, 8'($urandom_range(0, 63)), 2'b00}, $urandom,
           drd, dwr, {22'h0, 8'($urandom_range(0, 63)), 2'b00}, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
